// File: rtl/router_output_ctrl_tp.sv
// router_output_ctrl_tp: round-robin output-port controller for one security domain of the TP router
// Ports:
//    clk      - clock
//    reset    - synchronous active-high reset (priority pointer back to port 0)
//    reqs     - per-input-port requests, bit i = port i wants this output
//    grants   - one-hot grant to the winning port, zero when nothing transfers
//    out_val  - output-channel valid, set whenever any port requests
//    out_rdy  - downstream ready
//    xbar_sel - crossbar select, 3*domain + winning port index
module router_output_ctrl_tp #(
   parameter int domain = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] reqs,
   output logic [2:0] grants,
   output logic       out_val,
   input  logic       out_rdy,
   output logic [2:0] xbar_sel
);
   localparam logic [2:0] base = 3'(3 * domain);
   logic [1:0] ptr, p1, p2, winner;
   always_comb begin
      p1 = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      p2 = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
      winner = reqs[ptr] ? ptr : reqs[p1] ? p1 : p2;
      out_val = |reqs;
      grants = (out_val && out_rdy) ? 3'b001 << winner : 3'b000;
      xbar_sel = base + {1'b0, out_val ? winner : 2'd0};
   end
   // priority moves past the winner only when a transfer actually happens
   always_ff @(posedge clk)
      ptr <= reset ? 2'd0 : (|grants) ? ((winner == 2'd2) ? 2'd0 : winner + 2'd1) : ptr;
endmodule

// File: tb/tb_router_output_ctrl_tp.sv
// tb_router_output_ctrl_tp: directed checks of both domain instances of router_output_ctrl_tp
module tb_router_output_ctrl_tp;
   logic clk = 1'b0;
   logic reset;
   logic [2:0] reqs;
   logic out_rdy;
   logic [2:0] g0, g1, s0, s1;
   logic v0, v1;
   int vectors = 0;
   int errs = 0;
   always #5 clk = ~clk;
   router_output_ctrl_tp #(.domain(0)) dut0 (
      .clk(clk), .reset(reset), .reqs(reqs), .grants(g0),
      .out_val(v0), .out_rdy(out_rdy), .xbar_sel(s0)
   );
   router_output_ctrl_tp #(.domain(1)) dut1 (
      .clk(clk), .reset(reset), .reqs(reqs), .grants(g1),
      .out_val(v1), .out_rdy(out_rdy), .xbar_sel(s1)
   );
   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask
   // apply one cycle of stimulus at the falling edge and check both instances 1ns later
   task automatic step(input string tag, input logic rst, input logic [2:0] r, input logic rdy,
                       input logic [2:0] eg, input logic ev, input logic [2:0] esel);
      @(negedge clk);
      reset = rst;
      reqs = r;
      out_rdy = rdy;
      #1;
      chk({tag, ".d0.grants"}, g0, eg);
      chk({tag, ".d0.out_val"}, {2'b00, v0}, {2'b00, ev});
      chk({tag, ".d0.xbar_sel"}, s0, esel);
      chk({tag, ".d1.grants"}, g1, eg);
      chk({tag, ".d1.out_val"}, {2'b00, v1}, {2'b00, ev});
      chk({tag, ".d1.xbar_sel"}, s1, esel + 3'd3);
   endtask
   initial begin
      reset = 1'b1;
      reqs = 3'b000;
      out_rdy = 1'b0;
      step("rst_a", 1, 3'b000, 0, 3'b000, 0, 3'd0);
      step("rst_b", 1, 3'b000, 0, 3'b000, 0, 3'd0);
      step("idle", 0, 3'b000, 0, 3'b000, 0, 3'd0);
      step("blk100", 0, 3'b100, 0, 3'b000, 1, 3'd2);
      step("go100", 0, 3'b100, 1, 3'b100, 1, 3'd2);
      step("one010", 0, 3'b010, 1, 3'b010, 1, 3'd1);
      step("one001", 0, 3'b001, 1, 3'b001, 1, 3'd0);
      // ptr is now 1: reset cycle still grants combinationally, then ptr returns to 0
      step("rst_mid", 1, 3'b011, 1, 3'b010, 1, 3'd1);
      step("rr011a", 0, 3'b011, 1, 3'b001, 1, 3'd0);
      step("rr011b", 0, 3'b011, 1, 3'b010, 1, 3'd1);
      step("rr111a", 0, 3'b111, 1, 3'b100, 1, 3'd2);
      step("rr111b", 0, 3'b111, 1, 3'b001, 1, 3'd0);
      step("rr111c", 0, 3'b111, 1, 3'b010, 1, 3'd1);
      // ptr is 2: blocked request must not rotate priority
      step("blk101", 0, 3'b101, 0, 3'b000, 1, 3'd2);
      step("blk110", 0, 3'b110, 0, 3'b000, 1, 3'd2);
      step("none", 0, 3'b000, 1, 3'b000, 0, 3'd0);
      step("go101", 0, 3'b101, 1, 3'b100, 1, 3'd2);
      step("go110", 0, 3'b110, 1, 3'b010, 1, 3'd1);
      step("go011", 0, 3'b011, 1, 3'b001, 1, 3'd0);
      step("go111", 0, 3'b111, 1, 3'b010, 1, 3'd1);
      step("go101b", 0, 3'b101, 1, 3'b100, 1, 3'd2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/router_output_ctrl_tp.md
Name: router_output_ctrl_tp

Overview:
- Output-port controller for one router output in the timing-channel-protected (TP) network.
- Each instance serves one security domain.
- Each cycle it round-robin arbitrates among three input-port requests and drives the crossbar select for the winner.
- Grants are issued only when the downstream output is ready.
- The crossbar has six inputs (3 ports x 2 domains). The select is offset by the domain, so each domain's traffic uses its own crossbar inputs.

Parameters:
- domain, default 0: security domain served (0 or 1). Crossbar select offset = 3*domain.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- reqs  input  3  per-input-port request; bit i = input port i wants this output
- grants  output  3  one-hot grant to input port (all zero when nothing is granted)
- out_val  output  1  output-channel valid
- out_rdy  input  1  downstream ready
- xbar_sel  output  3  crossbar select = 3*domain + winning port index

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Datapath is purely combinational from reqs, out_rdy and the priority state. Zero-cycle latency.
- Only state: a round-robin priority pointer, ptr (0..2).
  - ptr = highest-priority port.
  - Search order: ptr, ptr+1, ptr+2 (mod 3).
- Reset: ptr <= 0, i.e. port 0 highest, then 1, then 2.
- Outputs during and after reset are combinational functions of the inputs; no other reset values are needed.
- winner = first port with reqs bit set, in priority order from ptr. Undefined/unused when reqs == 0.
- out_val = |reqs. It is independent of out_rdy.
- grants:
  - If out_rdy is 1 and reqs != 0: one-hot(winner).
  - Otherwise 3'b000.
  - Never more than one bit set.
- xbar_sel:
  - reqs != 0: 3*domain + winner (domain 0: 0..2; domain 1: 3..5).
  - reqs == 0: 3*domain.
- Priority update at posedge clk when not in reset: if any grant bit is set, ptr <= (winner+1) mod 3; otherwise ptr holds.
  - Priority therefore advances only on a completed transfer (reqs != 0 and out_rdy).
  - A blocked request (out_rdy = 0) does not rotate priority.
- Fairness: with all three ports requesting and out_rdy held high, each port is granted once every 3 cycles.
- Reset asserted mid-operation: ptr returns to 0 on that edge; grants in the reset cycle still follow the combinational rules.
- out_rdy = 0 with requests pending: grants = 000, out_val = 1, xbar_sel still reflects the current winner.

Test Plan:
- After reset, reqs=000, out_rdy=0 -> grants=000, out_val=0, xbar_sel=0.
- reqs=100, out_rdy=0 -> grants=000, out_val=1, xbar_sel=2, ptr unchanged. Next cycle reqs=100, out_rdy=1 -> grants=100, out_val=1, xbar_sel=2.
- Single requesters with out_rdy=1, in sequence:
  - reqs=010 -> grants=010, sel=1
  - reqs=001 -> grants=001, sel=0
- Round-robin, out_rdy=1:
  - From reset, reqs=011 for two cycles -> grants 001 (sel 0) then 010 (sel 1).
  - reqs=111 for three cycles -> each port granted exactly once, one-hot each cycle.
- reqs=101, out_rdy=0 -> grants=000, out_val=1; then reqs=000, out_rdy=1 -> grants=000, out_val=0.
- domain=1 instance, same sequence -> same grants/out_val, xbar_sel offset by 3 (reqs=100 -> sel 5, 010 -> 4, 001 -> 3).
